// File: rtl/dmem_port_ctrl.sv
// rtl/dmem_port_ctrl.sv - data-memory port controller: load/store sequencing over a bidirectional bus
// Optional feature macro: DMEM_SUBWORD_EN enables byte/half loads and read-modify-write subword stores.
module dmem_port_ctrl #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W+1:0] req_addr,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [31:0]       req_wdata,
  input  logic [4:0]        req_rd,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_data,
  output logic [4:0]        rsp_rd,
  output logic              mem_cs,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  inout  wire  [31:0]       mem_dat,
  output logic              misalign_err
);

  typedef enum logic [2:0] {IDLE, RD_ISSUE, RD_CAPT, WR, RSP} state_t;

  state_t            state_q, state_d;
  logic              write_q;
  logic [ADDR_W+1:0] addr_q;
  logic [1:0]        size_q;
  logic              signed_q;
  logic [31:0]       wdata_q, wdata_d;
  logic [4:0]        rd_q;
  logic [31:0]       rsp_data_q, rsp_data_d;
  logic              misalign_q;

  logic              accept;
  logic              misaligned;
  logic [4:0]        lane_sh;
  logic [31:0]       rd_shifted;
  logic [31:0]       lane_data;
  logic [31:0]       lane_mask;
  logic [31:0]       merged;

  assign accept = req_valid & req_ready;

`ifdef DMEM_SUBWORD_EN
  always_comb begin
    misaligned = 1'b0;
    case (req_size)
      2'b00:   misaligned = 1'b0;
      2'b01:   misaligned = req_addr[0];
      2'b10:   misaligned = |req_addr[1:0];
      default: misaligned = 1'b1;
    endcase
  end
`else
  assign misaligned = (req_size != 2'b10) | (|req_addr[1:0]);
`endif

  // Lane logic only sees subword sizes when the feature admits them past the alignment check.
  assign lane_sh    = {addr_q[1:0], 3'b000};
  assign rd_shifted = mem_dat >> lane_sh;

  always_comb begin
    lane_data = mem_dat;
    lane_mask = 32'hFFFF_FFFF;
    case (size_q)
      2'b00: begin
        lane_data = {{24{signed_q & rd_shifted[7]}}, rd_shifted[7:0]};
        lane_mask = 32'h0000_00FF << lane_sh;
      end
      2'b01: begin
        lane_data = {{16{signed_q & rd_shifted[15]}}, rd_shifted[15:0]};
        lane_mask = 32'h0000_FFFF << lane_sh;
      end
      default: begin
        lane_data = mem_dat;
        lane_mask = 32'hFFFF_FFFF;
      end
    endcase
  end

  assign merged = (mem_dat & ~lane_mask) | ((wdata_q << lane_sh) & lane_mask);

  always_comb begin
    state_d   = state_q;
    req_ready = 1'b0;
    mem_cs    = 1'b0;
    mem_we    = 1'b0;
    rsp_valid = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = rst_n;
        if (accept && !misaligned) begin
          state_d = (req_write && req_size == 2'b10) ? WR : RD_ISSUE;
        end
      end
      RD_ISSUE: begin
        mem_cs  = 1'b1;
        state_d = RD_CAPT;
      end
      RD_CAPT: begin
        mem_cs  = 1'b1;
        state_d = write_q ? WR : RSP;
      end
      WR: begin
        mem_cs  = 1'b1;
        mem_we  = 1'b1;
        state_d = IDLE;
      end
      RSP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    wdata_d    = wdata_q;
    rsp_data_d = rsp_data_q;
    if (accept) begin
      wdata_d = req_wdata;
    end else if (state_q == RD_CAPT) begin
      if (write_q) wdata_d = merged;
      else         rsp_data_d = lane_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      write_q    <= 1'b0;
      addr_q     <= '0;
      size_q     <= 2'b00;
      signed_q   <= 1'b0;
      wdata_q    <= '0;
      rd_q       <= '0;
      rsp_data_q <= '0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wdata_q    <= wdata_d;
      rsp_data_q <= rsp_data_d;
      misalign_q <= accept & misaligned;
      if (accept) begin
        write_q  <= req_write;
        addr_q   <= req_addr;
        size_q   <= req_size;
        signed_q <= req_signed;
        rd_q     <= req_rd;
      end
    end
  end

  assign mem_addr     = addr_q[ADDR_W+1:2];
  assign mem_dat      = (state_q == WR) ? wdata_q : 'z;
  assign rsp_data     = rsp_data_q;
  assign rsp_rd       = rd_q;
  assign misalign_err = misalign_q;

endmodule

// File: tb/tb_dmem_port_ctrl.sv
// tb/tb_dmem_port_ctrl.sv - directed self-checking bench for dmem_port_ctrl
module tb_dmem_port_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [9:0]  req_addr;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_wdata;
  logic [4:0]  req_rd;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic [4:0]  rsp_rd;
  logic        mem_cs;
  logic        mem_we;
  logic [7:0]  mem_addr;
  wire  [31:0] mem_dat;
  logic        misalign_err;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [256];
  logic [31:0] mem_rd_q;

  always #5 clk = ~clk;

  dmem_port_ctrl #(.ADDR_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_size(req_size), .req_signed(req_signed),
    .req_wdata(req_wdata), .req_rd(req_rd),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_rd(rsp_rd),
    .mem_cs(mem_cs), .mem_we(mem_we), .mem_addr(mem_addr), .mem_dat(mem_dat),
    .misalign_err(misalign_err)
  );

  // Synchronous SRAM with a registered read port that drives the bus while cs & ~we.
  always @(posedge clk) begin
    if (mem_cs) begin
      if (mem_we) mem[mem_addr] <= mem_dat;
      else        mem_rd_q <= mem[mem_addr];
    end
  end
  assign mem_dat = (mem_cs && !mem_we) ? mem_rd_q : 'z;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_ne(input string tag, input logic [31:0] obs, input logic [31:0] bad);
    checks++;
    assert (obs !== bad) else begin
      errors++;
      $error("FAIL %s observed=%h expected anything but %h", tag, obs, bad);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic wr, input logic [9:0] a, input logic [1:0] sz,
                       input logic sg, input logic [31:0] wd, input logic [4:0] rd);
    req_write  = wr;
    req_addr   = a;
    req_size   = sz;
    req_signed = sg;
    req_wdata  = wd;
    req_rd     = rd;
    req_valid  = 1'b1;
    step();
    req_valid  = 1'b0;
  endtask

  task automatic word_store(input logic [9:0] a, input logic [31:0] wd);
    issue(1'b1, a, 2'b10, 1'b0, wd, 5'd0);
    step();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem_rd_q   = 32'h0;
    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_write  = 1'b0;
    req_addr   = '0;
    req_size   = 2'b10;
    req_signed = 1'b0;
    req_wdata  = '0;
    req_rd     = '0;
    rsp_ready  = 1'b1;

    #3;
    check("rst_req_ready", {31'b0, req_ready}, 32'd0);
    check("rst_mem_cs", {31'b0, mem_cs}, 32'd0);
    check("rst_mem_we", {31'b0, mem_we}, 32'd0);
    check("rst_mem_addr", {24'b0, mem_addr}, 32'd0);
    check("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("rst_rsp_data", rsp_data, 32'd0);
    check("rst_rsp_rd", {27'b0, rsp_rd}, 32'd0);
    check("rst_misalign", {31'b0, misalign_err}, 32'd0);
    step();
    step();
    rst_n = 1'b1;
    #1;
    check("rel_req_ready", {31'b0, req_ready}, 32'd1);

    // Word store 0xDEADBEEF to byte 0x010
    issue(1'b1, 10'h010, 2'b10, 1'b0, 32'hDEADBEEF, 5'd0);
    check("wr_cs", {31'b0, mem_cs}, 32'd1);
    check("wr_we", {31'b0, mem_we}, 32'd1);
    check("wr_addr", {24'b0, mem_addr}, 32'h04);
    check("wr_dat", mem_dat, 32'hDEADBEEF);
    check("wr_ready", {31'b0, req_ready}, 32'd0);
    step();
    check("wr_done_cs", {31'b0, mem_cs}, 32'd0);
    check_ne("wr_done_bus", mem_dat, 32'hDEADBEEF);
    check("wr_mem", mem[4], 32'hDEADBEEF);
    check("wr_done_ready", {31'b0, req_ready}, 32'd1);
    check("wr_no_rsp", {31'b0, rsp_valid}, 32'd0);

    // Word load from 0x010, tag 7
    issue(1'b0, 10'h010, 2'b10, 1'b0, 32'h0, 5'd7);
    check("ld1_cs", {30'b0, mem_cs, mem_we}, 32'b10);
    check("ld1_rsp", {31'b0, rsp_valid}, 32'd0);
    step();
    check("ld2_cs", {30'b0, mem_cs, mem_we}, 32'b10);
    check("ld2_rsp", {31'b0, rsp_valid}, 32'd0);
    step();
    check("ld3_rsp", {31'b0, rsp_valid}, 32'd1);
    check("ld3_data", rsp_data, 32'hDEADBEEF);
    check("ld3_rd", {27'b0, rsp_rd}, 32'd7);
    check("ld3_cs", {31'b0, mem_cs}, 32'd0);
    step();
    check("ld_done_rsp", {31'b0, rsp_valid}, 32'd0);
    check("ld_done_ready", {31'b0, req_ready}, 32'd1);

    // Misaligned word load at 0x011
    issue(1'b0, 10'h011, 2'b10, 1'b0, 32'h0, 5'd2);
    check("mis_pulse", {31'b0, misalign_err}, 32'd1);
    check("mis_cs", {31'b0, mem_cs}, 32'd0);
    check("mis_ready", {31'b0, req_ready}, 32'd1);
    check("mis_rsp", {31'b0, rsp_valid}, 32'd0);
    step();
    check("mis_pulse_end", {31'b0, misalign_err}, 32'd0);
    check("mis_rsp2", {31'b0, rsp_valid}, 32'd0);

    // Illegal size 11 at an aligned address
    issue(1'b0, 10'h020, 2'b11, 1'b0, 32'h0, 5'd2);
    check("sz11_pulse", {31'b0, misalign_err}, 32'd1);
    check("sz11_cs", {31'b0, mem_cs}, 32'd0);
    step();
    check("sz11_end", {31'b0, misalign_err}, 32'd0);

    // Half store 0xABCD at 0x012 over 0x11223344
    word_store(10'h010, 32'h11223344);
    check("pre_half_mem", mem[4], 32'h11223344);
    issue(1'b1, 10'h012, 2'b01, 1'b0, 32'h0000ABCD, 5'd0);
`ifdef DMEM_SUBWORD_EN
    check("hs_rmw_rd", {30'b0, mem_cs, mem_we}, 32'b10);
    step();
    step();
    check("hs_wr", {30'b0, mem_cs, mem_we}, 32'b11);
    check("hs_bus", mem_dat, 32'hABCD3344);
    step();
    check("hs_mem", mem[4], 32'hABCD3344);
    check("hs_no_rsp", {31'b0, rsp_valid}, 32'd0);
`else
    check("hs_mis", {31'b0, misalign_err}, 32'd1);
    check("hs_cs", {31'b0, mem_cs}, 32'd0);
    step();
    check("hs_mem", mem[4], 32'h11223344);
`endif

    // Byte loads at 0x013 over 0x80FF1234
    word_store(10'h010, 32'h80FF1234);
    issue(1'b0, 10'h013, 2'b00, 1'b1, 32'h0, 5'd9);
`ifdef DMEM_SUBWORD_EN
    step();
    step();
    check("lbs_valid", {31'b0, rsp_valid}, 32'd1);
    check("lbs_data", rsp_data, 32'hFFFFFF80);
    step();
    issue(1'b0, 10'h013, 2'b00, 1'b0, 32'h0, 5'd9);
    step();
    step();
    check("lbu_data", rsp_data, 32'h00000080);
    step();
`else
    check("lb_mis", {31'b0, misalign_err}, 32'd1);
    check("lb_cs", {31'b0, mem_cs}, 32'd0);
    step();
    check("lb_no_rsp", {31'b0, rsp_valid}, 32'd0);
`endif

    // Response back-pressure for four cycles
    rsp_ready = 1'b0;
    issue(1'b0, 10'h010, 2'b10, 1'b0, 32'h0, 5'd3);
    step();
    step();
    for (int i = 0; i < 4; i++) begin
      check("bp_valid", {31'b0, rsp_valid}, 32'd1);
      check("bp_data", rsp_data, 32'h80FF1234);
      check("bp_rd", {27'b0, rsp_rd}, 32'd3);
      check("bp_ready", {31'b0, req_ready}, 32'd0);
      step();
    end
    rsp_ready = 1'b1;
    #1;
    check("bp_still_valid", {31'b0, rsp_valid}, 32'd1);
    step();
    check("bp_release", {31'b0, rsp_valid}, 32'd0);
    check("bp_ready_back", {31'b0, req_ready}, 32'd1);

    // Reset asserted while in WR: no write, bus released
    issue(1'b1, 10'h020, 2'b10, 1'b0, 32'h00000055, 5'd0);
    check("rw_in_wr", {30'b0, mem_cs, mem_we}, 32'b11);
    rst_n = 1'b0;
    #1;
    check("rw_cs", {31'b0, mem_cs}, 32'd0);
    check("rw_we", {31'b0, mem_we}, 32'd0);
    check_ne("rw_bus", mem_dat, 32'h00000055);
    check("rw_ready", {31'b0, req_ready}, 32'd0);
    check("rw_addr", {24'b0, mem_addr}, 32'd0);
    step();
    rst_n = 1'b1;
    #1;
    check("rw_rel_ready", {31'b0, req_ready}, 32'd1);
    check("rw_no_write", mem[8], 32'h0);
    step();
    check("rw_no_write2", mem[8], 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
